// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the decrypt datapath.
// Latency: n/a (package).
// Backpressure: n/a (package).
package aes_pkg;

    localparam int NR    = 10;
    localparam int NK    = 4;
    localparam int BLK_W = 32 * NK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_mul2(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_cipher_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
module inv_cipher_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_in,
    input  logic [BLK_W-1:0] round_key,
    input  logic             last,
    output logic [BLK_W-1:0] state_out
);

    logic [7:0] in_b  [16];
    logic [7:0] ark_b [16];
    logic [7:0] mc_b  [16];

    // Bytes are indexed row + 4*col, byte 0 in the top bits of the block.
    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            in_b[i] = state_in[127 - 8*i -: 8];
        end
        // Row r rotates right by r columns, then S-box inverse and key mix.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark_b[r + 4*c] = inv_sbox(in_b[r + 4*((c - r + 4) % 4)])
                                 ^ round_key[127 - 8*(r + 4*c) -: 8];
            end
        end
        // Column mix with the circulant {0e,0b,0d,09}.
        for (int c = 0; c < 4; c++) begin
            mc_b[4*c + 0] = gf_mul(ark_b[4*c + 0], 8'h0e) ^ gf_mul(ark_b[4*c + 1], 8'h0b)
                          ^ gf_mul(ark_b[4*c + 2], 8'h0d) ^ gf_mul(ark_b[4*c + 3], 8'h09);
            mc_b[4*c + 1] = gf_mul(ark_b[4*c + 0], 8'h09) ^ gf_mul(ark_b[4*c + 1], 8'h0e)
                          ^ gf_mul(ark_b[4*c + 2], 8'h0b) ^ gf_mul(ark_b[4*c + 3], 8'h0d);
            mc_b[4*c + 2] = gf_mul(ark_b[4*c + 0], 8'h0d) ^ gf_mul(ark_b[4*c + 1], 8'h09)
                          ^ gf_mul(ark_b[4*c + 2], 8'h0e) ^ gf_mul(ark_b[4*c + 3], 8'h0b);
            mc_b[4*c + 3] = gf_mul(ark_b[4*c + 0], 8'h0b) ^ gf_mul(ark_b[4*c + 1], 8'h0d)
                          ^ gf_mul(ark_b[4*c + 2], 8'h09) ^ gf_mul(ark_b[4*c + 3], 8'h0e);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = last ? ark_b[i] : mc_b[i];
        end
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock from an external round-key store.
// Latency: accept edge T -> out_valid after edge T+10; 12 cycles per block back-to-back.
// Backpressure: holds result in DONE until out_ready; in_ready low from accept until DONE->IDLE.
module aes128_decrypt_iter #(
    parameter int NR       = aes_pkg::NR,
    parameter int RK_IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [aes_pkg::BLK_W-1:0] in_data,
    output logic [RK_IDX_W-1:0]       rk_idx,
    input  logic [aes_pkg::BLK_W-1:0] round_key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [aes_pkg::BLK_W-1:0] out_data,
    output logic                      busy
);

    localparam logic [RK_IDX_W-1:0] RND_FIRST = RK_IDX_W'(NR - 1);
    localparam logic [RK_IDX_W-1:0] RK_INIT   = RK_IDX_W'(NR);

    aes_pkg::state_e           state_q, state_d;
    logic [RK_IDX_W-1:0]       rnd_q, rnd_d;
    logic [RK_IDX_W-1:0]       rk_idx_q, rk_idx_d;
    logic [aes_pkg::BLK_W-1:0] state_reg_q, state_reg_d;
    logic [aes_pkg::BLK_W-1:0] out_data_q;
    logic [aes_pkg::BLK_W-1:0] round_out;
    logic                      in_ready_q;
    logic                      last_round;
    logic                      accept;

    assign last_round = (rnd_q == '0);
    assign accept     = in_valid && in_ready_q && (state_q == aes_pkg::ST_IDLE);

    inv_cipher_round u_round (
        .state_in  (state_reg_q),
        .round_key (round_key),
        .last      (last_round),
        .state_out (round_out)
    );

    // Next state, round counter, datapath register and the key index for the next cycle.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        state_reg_d = state_reg_q;
        case (state_q)
            aes_pkg::ST_IDLE: begin
                if (accept) begin
                    state_reg_d = in_data ^ round_key;
                    rnd_d       = RND_FIRST;
                    state_d     = aes_pkg::ST_ROUND;
                end
            end
            aes_pkg::ST_ROUND: begin
                state_reg_d = round_out;
                if (last_round) begin
                    state_d = aes_pkg::ST_DONE;
                end else begin
                    rnd_d = rnd_q - RK_IDX_W'(1);
                end
            end
            aes_pkg::ST_DONE: begin
                if (out_ready) state_d = aes_pkg::ST_IDLE;
            end
            default: state_d = aes_pkg::ST_IDLE;
        endcase
        // Registering the index keeps it glitch-free toward the key store.
        rk_idx_d = (state_d == aes_pkg::ST_ROUND) ? rnd_d : RK_INIT;
    end

    // State and control registers; reset drops any block in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= aes_pkg::ST_IDLE;
            rnd_q       <= RND_FIRST;
            rk_idx_q    <= RK_INIT;
            state_reg_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            rk_idx_q    <= rk_idx_d;
            state_reg_q <= state_reg_d;
            in_ready_q  <= (state_d == aes_pkg::ST_IDLE);
        end
    end

    // Output register loads the plaintext as the last round completes and holds it afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q <= '0;
        end else if (state_q == aes_pkg::ST_ROUND && last_round) begin
            out_data_q <= round_out;
        end
    end

    assign in_ready  = in_ready_q;
    assign rk_idx    = rk_idx_q;
    assign out_valid = (state_q == aes_pkg::ST_DONE);
    assign out_data  = out_data_q;
    assign busy      = (state_q != aes_pkg::ST_IDLE);

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for the iterative AES-128 decryptor with a byte-level FIPS model and key store.
// Latency: n/a.
// Backpressure: drives out_ready low in one scenario to exercise the DONE stall.
module tb_aes128_decrypt_iter;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]   sbox   [256];
    logic [7:0]   inv_sb [256];
    logic [127:0] rk     [16];

    aes128_decrypt_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Zero-latency external key store.
    always_comb round_key = rk[rk_idx];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    // Carry-less product followed by reduction modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] imc_coef(input int row, input int k);
        case ((k - row + 4) % 4)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // S-box from the multiplicative inverse and affine map; inverse table by inversion.
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] iv;
            logic [7:0] s;
            iv = 8'h00;
            for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) iv = 8'(c);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            sbox[b]  = s;
            inv_sb[s] = 8'(b);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Inverse cipher on a 4x4 byte matrix, byte index row + 4*col.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk[10][127 - 8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    t[ro + 4*((c + ro) % 4)] = inv_sb[s[ro + 4*c]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk[r][127 - 8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int ro = 0; ro < 4; ro++) begin
                        s[ro + 4*c] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[ro + 4*c] = s[ro + 4*c] ^ gmul(imc_coef(ro, k), t[k + 4*c]);
                    end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Monitor / scoreboard state.
    logic [127:0] exp_q [$];
    int           acc_cyc [$];
    int           cyc = 0;
    int           k = 0;
    bit           inflight = 0;
    bit           after_reset = 1;
    logic [127:0] prev_out = '0;
    logic [127:0] last_pt = '0;
    int           done_count = 0;

    // Per-cycle compare against the timing rules and the plaintext scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("rst_in_ready", 128'(in_ready), 128'd0);
            check("rst_out_valid", 128'(out_valid), 128'd0);
            check("rst_busy", 128'(busy), 128'd0);
            inflight = 0;
            exp_q.delete();
            after_reset = 1;
        end else begin
            if (!inflight) begin
                check("idle_out_valid", 128'(out_valid), 128'd0);
                check("idle_busy", 128'(busy), 128'd0);
                check("idle_rk_idx", 128'(rk_idx), 128'd10);
                if (!after_reset) check("idle_in_ready", 128'(in_ready), 128'd1);
                if (in_valid && in_ready) begin
                    inflight = 1;
                    k = 0;
                    exp_q.push_back(model_decrypt(in_data));
                    acc_cyc.push_back(cyc);
                end
            end else begin
                k++;
                check("run_in_ready", 128'(in_ready), 128'd0);
                check("run_busy", 128'(busy), 128'd1);
                if (k <= 10) begin
                    check("round_out_valid", 128'(out_valid), 128'd0);
                    check("round_rk_idx", 128'(rk_idx), 128'(10 - k));
                end else begin
                    check("done_out_valid", 128'(out_valid), 128'd1);
                    check("done_out_data", out_data, exp_q[0]);
                    if (k > 11) check("done_stable", out_data, prev_out);
                    prev_out = out_data;
                    if (out_ready) begin
                        last_pt = out_data;
                        void'(exp_q.pop_front());
                        inflight = 0;
                        done_count++;
                    end
                end
            end
            after_reset = 0;
        end
    end

    // Called just after a rising edge; holds in_valid until the block is taken.
    task automatic send(input logic [127:0] ct);
        bit acc;
        int t;
        in_valid = 1'b1;
        in_data  = ct;
        t = 0;
        acc = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_accept_timeout", 128'(acc), 128'd1);
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_count < n && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_count < n) check("wait_done_timeout", 128'(done_count), 128'(n));
    endtask

    initial begin
        int t;
        int n0;
        int d0;

        build_sbox();
        check("model_sbox_53", 128'(sbox[8'h53]), 128'h00ed);
        check("model_invsbox_00", 128'(inv_sb[8'h00]), 128'h0052);
        expand_key(KEY_B);
        check("model_rk10_b", rk[10], RK10_B);
        check("model_pt_b", model_decrypt(CT_B), PT_B);
        expand_key(KEY_C1);
        check("model_rk10_c1", rk[10], RK10_C1);
        check("model_pt_c1", model_decrypt(CT_C1), PT_C1);

        // Reset held for a few cycles, released just after an edge.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // FIPS-197 C.1 vector.
        send(CT_C1);
        wait_done(1);
        check("c1_plaintext", last_pt, PT_C1);

        // FIPS-197 Appendix B vector.
        expand_key(KEY_B);
        send(CT_B);
        wait_done(2);
        check("b_plaintext", last_pt, PT_B);

        // Output stalled for 20 cycles in DONE.
        out_ready = 1'b0;
        send(CT_B);
        t = 0;
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("bp_reached_done", 128'(out_valid), 128'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_hold_valid", 128'(out_valid), 128'd1);
        check("bp_hold_data", out_data, PT_B);
        check("bp_hold_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(3);
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_plaintext", last_pt, PT_B);
        @(posedge clk); #1;

        // Three blocks with in_valid held high throughout.
        n0 = acc_cyc.size();
        send(CT_B);
        send(CT_C1);
        send(128'hffeeddccbbaa99887766554433221100);
        wait_done(6);
        check("b2b_count", 128'(acc_cyc.size() - n0), 128'd3);
        if (acc_cyc.size() - n0 == 3) begin
            check("b2b_gap_1", 128'(acc_cyc[n0+1] - acc_cyc[n0]), 128'd12);
            check("b2b_gap_2", 128'(acc_cyc[n0+2] - acc_cyc[n0+1]), 128'd12);
        end

        // Reset in the middle of a block at round 5.
        expand_key(KEY_C1);
        send(CT_C1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rk_idx != 4'd5 && t < 20);
        check("mid_reached_rnd5", 128'(rk_idx), 128'd5);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        d0 = done_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_post_in_ready", 128'(in_ready), 128'd1);
        repeat (13) @(posedge clk);
        #1;
        check("mid_no_output", 128'(done_count), 128'(d0));
        send(CT_C1);
        wait_done(d0 + 1);
        check("mid_next_plaintext", last_pt, PT_C1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=0", 1);
        $fatal(1, "timeout");
    end

endmodule
